ped_button_conditioner: RTL and testbench
=========================================

Name: ped_button_conditioner

Overview:
- Upstream stage of the traffic-light controller: turns the raw, asynchronous, bouncing pedestrian push-button into a synchronized, debounced level, a single-cycle press pulse, and a sticky pedestrian request.
- The request holds until the controller acknowledges it with req_clr.
- Drives the controller's pedestrian-request input in place of the raw button; press_count feeds the LED debug bank.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on button_raw; legal range 2..4.
- DEBOUNCE_CYCLES, 16, consecutive equal synchronized samples required to accept a level change; legal range 2..2^20.
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock, the single-ended output of the differential clock buffer.
- rst_n  input  1  synchronous reset, active-low.
- button_raw  input  1  raw push-button; asynchronous to clk, may bounce.
- req_clr  input  1  one-cycle acknowledge from the controller; clears ped_request.
- button_clean  output  1  debounced button level.
- press_pulse  output  1  one-cycle high on each accepted press (debounced rising edge).
- ped_request  output  1  sticky pedestrian request to the controller.
- press_count  output  8  count of accepted presses, wraps modulo 256.

Behaviour:
- Reset: on any clk edge with rst_n=0, all state is cleared.
  - Synchronizer flops, counter and press_count go to 0.
  - FSM goes to RELEASED.
  - button_clean, press_pulse and ped_request go to 0.
  - Reset asserted mid-debounce discards the partial count. After release, the FSM starts again from RELEASED, so a button held through reset is accepted only after a full fresh latency.
- Synchronizer:
  - s = last stage of a SYNC_STAGES-deep flop chain on button_raw.
  - The FSM uses only s, never button_raw.
- FSM, four states; counter cnt:
  - RELEASED (button_clean=0): if s=1, go to PRESS_WAIT with cnt=1; else stay.
  - PRESS_WAIT (button_clean=0):
    - If s=0, go to RELEASED and set cnt=0 (a bounce).
    - Else if cnt=DEBOUNCE_CYCLES-1, go to PRESSED, set button_clean=1 and assert press_pulse for this one cycle.
    - Else cnt=cnt+1.
  - PRESSED (button_clean=1): if s=0, go to RELEASE_WAIT with cnt=1; else stay.
  - RELEASE_WAIT (button_clean=1):
    - If s=1, go to PRESSED and set cnt=0.
    - Else if cnt=DEBOUNCE_CYCLES-1, go to RELEASED and set button_clean=0. No pulse is generated on release.
    - Else cnt=cnt+1.
- Latency:
  - Let edge N be the first edge at which button_raw is sampled high, with the button held stable afterwards.
  - button_clean and press_pulse are registered at edge N+SYNC_STAGES+DEBOUNCE_CYCLES-1. With defaults that is edge N+17.
  - Release latency is identical.
  - All outputs are registered; there are no combinational paths from inputs to outputs.
- press_pulse: exactly one cycle per accepted press, never two in consecutive cycles. Minimum spacing between pulses is 2*DEBOUNCE_CYCLES cycles.
- ped_request:
  - Set to 1 on the edge after press_pulse=1.
  - Cleared on the edge after req_clr=1.
  - If press_pulse and req_clr are high in the same cycle, set wins: ped_request=1, because the press is a new request after the acknowledged one.
  - req_clr while ped_request=0 has no effect.
  - Repeated presses while ped_request is already 1 keep it at 1 and still increment press_count.
- press_count: incremented on the edge after press_pulse; 255 wraps to 0. It is not affected by req_clr.
- Glitches: a high or low run on s shorter than DEBOUNCE_CYCLES samples produces no change on button_clean and no pulse.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2 for sim):
- Clean press: rst_n low for 3 cycles then high; raise button_raw at edge N and hold -> button_clean=1 and a single press_pulse at edge N+5; ped_request=1 and press_count=1 at edge N+6.
- Bounce: button_raw high 2 cycles, low 1, high 3, low 1, then low held -> button_clean, press_pulse and ped_request stay 0 throughout.
- Release debounce: from PRESSED, drop button_raw at edge M -> button_clean=0 at edge M+5, no pulse. A low glitch of 2 cycles while pressed -> button_clean stays 1.
- Request handshake: after a press, pulse req_clr for 1 cycle -> ped_request=0 next edge, press_count unchanged. Then drive req_clr coincident with a new press_pulse -> ped_request remains 1, press_count increments.
- Reset mid-operation: assert rst_n=0 while in PRESS_WAIT with cnt=2 and button held -> all outputs 0. After release, press_pulse occurs exactly 4 edges after the first post-reset edge sampling s=1, i.e. no partial credit.
- Wrap: 256 accepted presses -> press_count returns to 0, ped_request=1.

Source files
------------

// File: rtl/ped_button_conditioner.sv
// rtl/ped_button_conditioner.sv - synchronize, debounce and latch the pedestrian push-button
module ped_button_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       button_raw,
  input  logic       req_clr,
  output logic       button_clean,
  output logic       press_pulse,
  output logic       ped_request,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  state_t                 state;
  logic [CNT_W-1:0]       cnt;

  assign s = sync[SYNC_STAGES-1];

  // button_raw is asynchronous; only the last stage of this chain is ever used
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], button_raw};
    end
  end

  // cnt holds how many consecutive samples of s have disagreed with button_clean
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= RELEASED;
      cnt          <= '0;
      button_clean <= 1'b0;
      press_pulse  <= 1'b0;
    end else begin
      press_pulse <= 1'b0;
      case (state)
        RELEASED: begin
          button_clean <= 1'b0;
          if (s) begin
            state <= PRESS_WAIT;
            cnt   <= CNT_ONE;
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state        <= PRESSED;
            cnt          <= '0;
            button_clean <= 1'b1;
            press_pulse  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        PRESSED: begin
          button_clean <= 1'b1;
          if (!s) begin
            state <= RELEASE_WAIT;
            cnt   <= CNT_ONE;
          end
        end
        RELEASE_WAIT: begin
          if (s) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state        <= RELEASED;
            cnt          <= '0;
            button_clean <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state        <= RELEASED;
          cnt          <= '0;
          button_clean <= 1'b0;
        end
      endcase
    end
  end

  // a press arriving with an acknowledge is a fresh request, so set wins over clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ped_request <= 1'b0;
      press_count <= 8'd0;
    end else begin
      if (press_pulse) begin
        ped_request <= 1'b1;
        press_count <= press_count + 8'd1;
      end else if (req_clr) begin
        ped_request <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ped_button_conditioner.sv
// tb/tb_ped_button_conditioner.sv - self-checking bench for ped_button_conditioner
module tb_ped_button_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic       clk;
  logic       rst_n;
  logic       button_raw;
  logic       req_clr;
  logic       button_clean;
  logic       press_pulse;
  logic       ped_request;
  logic [7:0] press_count;

  int vectors;
  int miscompares;

  // reference model: s is button_raw delayed SYNC samples; the clean level flips
  // once DEB consecutive samples of s disagree with it
  logic [SYNC-1:0] m_hist;
  logic            m_clean;
  logic            m_pulse;
  logic            m_req;
  logic [7:0]      m_count;
  int              m_run;

  ped_button_conditioner #(
    .SYNC_STAGES(SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(20)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .button_raw(button_raw),
    .req_clr(req_clr),
    .button_clean(button_clean),
    .press_pulse(press_pulse),
    .ped_request(ped_request),
    .press_count(press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_edge(input logic r, input logic c, input logic n);
    logic s;
    logic np;
    if (!n) begin
      m_hist  = '0;
      m_clean = 1'b0;
      m_pulse = 1'b0;
      m_req   = 1'b0;
      m_count = 8'd0;
      m_run   = 0;
    end else begin
      s      = m_hist[SYNC-1];
      m_hist = {m_hist[SYNC-2:0], r};
      if (m_pulse) begin
        m_req   = 1'b1;
        m_count = m_count + 8'd1;
      end else if (c) begin
        m_req = 1'b0;
      end
      np = 1'b0;
      if (s != m_clean) begin
        m_run = m_run + 1;
        if (m_run == DEB) begin
          m_clean = s;
          m_run   = 0;
          np      = s;
        end
      end else begin
        m_run = 0;
      end
      m_pulse = np;
    end
  endtask

  task automatic step(input logic r, input logic c, input logic n);
    button_raw = r;
    req_clr    = c;
    rst_n      = n;
    @(posedge clk);
    model_edge(r, c, n);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0);
      vectors++;
      if ({button_clean, press_pulse, ped_request, press_count} !== 11'd0) begin
        miscompares++;
        $display("FAIL reset_outputs cyc=%0d got=%h exp=%h", i,
                 {button_clean, press_pulse, ped_request, press_count}, 11'd0);
      end
    end
  endtask

  task automatic test_clean_press();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 9; k++) begin
      step(1'b1, 1'b0, 1'b1);
      vectors++;
      if ({button_clean, press_pulse, ped_request, press_count} !==
          {(k >= 5), (k == 5), (k >= 6), ((k >= 6) ? 8'd1 : 8'd0)}) begin
        miscompares++;
        $display("FAIL clean_press k=%0d got=%h exp=%h", k,
                 {button_clean, press_pulse, ped_request, press_count},
                 {(k >= 5), (k == 5), (k >= 6), ((k >= 6) ? 8'd1 : 8'd0)});
      end
    end
  endtask

  task automatic test_bounce();
    logic [16:0] pat;
    pat = 17'b1101110_0000000000;
    step(1'b0, 1'b0, 1'b0);
    for (int k = 16; k >= 0; k--) begin
      step(pat[k], 1'b0, 1'b1);
      vectors++;
      if ({button_clean, press_pulse, ped_request} !== 3'b000) begin
        miscompares++;
        $display("FAIL bounce k=%0d got=%b exp=000", k, {button_clean, press_pulse, ped_request});
      end
    end
  endtask

  task automatic test_release();
    step(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      step((k >= 2), 1'b0, 1'b1);
      vectors++;
      if ({button_clean, press_pulse} !== 2'b10) begin
        miscompares++;
        $display("FAIL low_glitch k=%0d got=%b exp=10", k, {button_clean, press_pulse});
      end
    end
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0, 1'b1);
      vectors++;
      if ({button_clean, press_pulse} !== {(k < 5), 1'b0}) begin
        miscompares++;
        $display("FAIL release k=%0d got=%b exp=%b", k, {button_clean, press_pulse}, {(k < 5), 1'b0});
      end
    end
  endtask

  task automatic test_handshake();
    step(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    vectors++;
    if ({ped_request, press_count} !== {1'b0, 8'd1}) begin
      miscompares++;
      $display("FAIL req_clr got=%h exp=%h", {ped_request, press_count}, {1'b0, 8'd1});
    end
    step(1'b1, 1'b1, 1'b1);
    vectors++;
    if (ped_request !== 1'b0) begin
      miscompares++;
      $display("FAIL req_clr_idle got=%b exp=0", ped_request);
    end
    for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 1'b1);
    vectors++;
    if (press_pulse !== 1'b1) begin
      miscompares++;
      $display("FAIL second_pulse got=%b exp=1", press_pulse);
    end
    step(1'b1, 1'b1, 1'b1);
    vectors++;
    if ({ped_request, press_count} !== {1'b1, 8'd2}) begin
      miscompares++;
      $display("FAIL set_wins got=%h exp=%h", {ped_request, press_count}, {1'b1, 8'd2});
    end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 1'b0, 1'b0);
      vectors++;
      if ({button_clean, press_pulse, ped_request, press_count} !== 11'd0) begin
        miscompares++;
        $display("FAIL reset_mid k=%0d got=%h exp=0", k, {button_clean, press_pulse, ped_request, press_count});
      end
    end
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0, 1'b1);
      vectors++;
      if ({button_clean, press_pulse} !== {(k >= 5), (k == 5)}) begin
        miscompares++;
        $display("FAIL no_partial_credit k=%0d got=%b exp=%b", k, {button_clean, press_pulse}, {(k >= 5), (k == 5)});
      end
    end
  endtask

  task automatic test_random();
    int   len;
    logic r;
    logic c;
    logic n;
    logic prev;
    int   last;
    len  = 0;
    r    = 1'b0;
    prev = 1'b0;
    last = -1000;
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      if (len == 0) begin
        r   = 1'($urandom_range(0, 1));
        len = $urandom_range(1, 10);
      end
      len--;
      c = ($urandom_range(0, 7) == 0);
      n = ($urandom_range(0, 399) != 0);
      step(r, c, n);
      vectors++;
      if ({button_clean, press_pulse, ped_request, press_count} !== {m_clean, m_pulse, m_req, m_count}) begin
        miscompares++;
        $display("FAIL random_model cyc=%0d got=%h exp=%h", i,
                 {button_clean, press_pulse, ped_request, press_count}, {m_clean, m_pulse, m_req, m_count});
      end
      if (!n) last = -1000;
      if (press_pulse === 1'b1) begin
        vectors++;
        if (prev === 1'b1 || (i - last) < 2 * DEB) begin
          miscompares++;
          $display("FAIL pulse_spacing cyc=%0d got=%0d exp>=%0d", i, i - last, 2 * DEB);
        end
        last = i;
      end
      prev = press_pulse;
    end
  endtask

  task automatic test_wrap();
    step(1'b0, 1'b0, 1'b0);
    for (int p = 0; p < 256; p++) begin
      for (int k = 0; k < 14; k++) begin
        step((k < 7), 1'b0, 1'b1);
        vectors++;
        if ({button_clean, press_pulse, ped_request, press_count} !== {m_clean, m_pulse, m_req, m_count}) begin
          miscompares++;
          $display("FAIL wrap_model p=%0d k=%0d got=%h exp=%h", p, k,
                   {button_clean, press_pulse, ped_request, press_count}, {m_clean, m_pulse, m_req, m_count});
        end
      end
    end
    vectors++;
    if ({ped_request, press_count} !== {1'b1, 8'd0}) begin
      miscompares++;
      $display("FAIL wrap_final got=%h exp=%h", {ped_request, press_count}, {1'b1, 8'd0});
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    button_raw  = 1'b0;
    req_clr     = 1'b0;
    rst_n       = 1'b0;
    m_hist      = '0;
    m_clean     = 1'b0;
    m_pulse     = 1'b0;
    m_req       = 1'b0;
    m_count     = 8'd0;
    m_run       = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_handshake();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
